// File: rtl/seg7_capture.sv
// Receive-side monitor for a multiplexed active-low 7-segment bus: filters scan
// transitions and latches each stable digit pattern as hex. Optional macro SEG7_CAPTURE_DP_EN.
module seg7_capture #(
    parameter int N_DIGITS    = 4,
    parameter int STABLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 65536
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [6:0]                seg_in,
    input  logic [N_DIGITS-1:0]       an_in,
`ifdef SEG7_CAPTURE_DP_EN
    input  logic                      dp_in,
    output logic [N_DIGITS-1:0]       dp_out,
`endif
    input  logic                      err_clr,
    output logic [4*N_DIGITS-1:0]     digit_out,
    output logic [N_DIGITS-1:0]       digit_vld,
    output logic [N_DIGITS-1:0]       digit_blank,
    output logic                      upd,
    output logic [((N_DIGITS > 1) ? $clog2(N_DIGITS) : 1)-1:0] upd_idx,
    output logic                      err_code,
    output logic                      err_multi
);
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int CNT_W = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
    localparam int AGE_W = $clog2(TIMEOUT_CYC + 1);
`ifdef SEG7_CAPTURE_DP_EN
    localparam int PAT_W = N_DIGITS + 8;
`else
    localparam int PAT_W = N_DIGITS + 7;
`endif

    typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, HELD = 2'd2} state_t;

    logic [6:0]          seg_m_q, s_seg;
    logic [N_DIGITS-1:0] an_m_q, s_an;
    logic [PAT_W-1:0]    pat, prev_q;

    // Synchronisers idle at all-ones so reset looks like a dark, deselected bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_m_q <= '1;
            s_seg   <= '1;
            an_m_q  <= '1;
            s_an    <= '1;
        end else begin
            seg_m_q <= seg_in;
            s_seg   <= seg_m_q;
            an_m_q  <= an_in;
            s_an    <= an_m_q;
        end
    end

`ifdef SEG7_CAPTURE_DP_EN
    logic dp_m_q, s_dp;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_m_q <= 1'b1;
            s_dp   <= 1'b1;
        end else begin
            dp_m_q <= dp_in;
            s_dp   <= dp_m_q;
        end
    end
    assign pat = {s_an, s_dp, s_seg};
`else
    assign pat = {s_an, s_seg};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) prev_q <= '1;
        else     prev_q <= pat;
    end

    logic             change, all_off, at_target;
    logic [CNT_W-1:0] cnt_q, cnt_d, run;
    state_t           state_q, state_d;
    logic             capture, stable;

    assign change    = (pat != prev_q);
    assign all_off   = &s_an;
    // run is the count of back-to-back identical samples seen so far, minus one.
    assign run       = change ? '0 : cnt_q + 1'b1;
    assign at_target = (run == CNT_W'(STABLE_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            IDLE:    if (!all_off) state_d = at_target ? HELD : SETTLE;
            SETTLE:  if (all_off) state_d = IDLE;
                     else if (at_target) state_d = HELD;
            HELD:    if (all_off) state_d = IDLE;
                     else if (change) state_d = at_target ? HELD : SETTLE;
            default: state_d = IDLE;
        endcase
        if (state_d == SETTLE) cnt_d = run;
    end

    always_comb begin
        capture = 1'b0;
        case (state_q)
            IDLE, SETTLE: capture = !all_off && at_target;
            HELD:         capture = !all_off && change && at_target;
            default:      capture = 1'b0;
        endcase
        // Errors track the pattern for as long as it stays stable, so err_clr cannot mask a live fault.
        stable = capture || (state_q == HELD && !change && !all_off);
    end

    logic [3:0]          hex;
    logic                code_ok, is_blank, one_low, cap_ok;
    logic [N_DIGITS-1:0] inv;
    logic [IDX_W-1:0]    idx;

    always_comb begin
        code_ok = 1'b1;
        hex     = 4'h0;
        case (s_seg)
            7'h40: hex = 4'h0;  7'h79: hex = 4'h1;  7'h24: hex = 4'h2;  7'h30: hex = 4'h3;
            7'h19: hex = 4'h4;  7'h12: hex = 4'h5;  7'h02: hex = 4'h6;  7'h78: hex = 4'h7;
            7'h00: hex = 4'h8;  7'h10: hex = 4'h9;  7'h08: hex = 4'hA;  7'h03: hex = 4'hB;
            7'h46: hex = 4'hC;  7'h21: hex = 4'hD;  7'h06: hex = 4'hE;  7'h0E: hex = 4'hF;
            default: code_ok = 1'b0;
        endcase
    end

    assign is_blank = (s_seg == 7'h7F);
    assign inv      = ~s_an;
    assign one_low  = (inv != '0) && ((inv & (inv - 1'b1)) == '0);
    assign cap_ok   = capture && one_low && (code_ok || is_blank);

    always_comb begin
        idx = '0;
        for (int i = 0; i < N_DIGITS; i++)
            if (!s_an[i]) idx = IDX_W'(i);
    end

    for (genvar g = 0; g < N_DIGITS; g++) begin : g_digit
        logic             hit;
        logic [AGE_W-1:0] age_q;
        logic             vld_q, blank_q;
        logic [3:0]       dig_q;

        assign hit = cap_ok && (idx == IDX_W'(g));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                age_q   <= '0;
                vld_q   <= 1'b0;
                blank_q <= 1'b0;
                dig_q   <= '0;
            end else if (hit) begin
                age_q   <= '0;
                vld_q   <= code_ok;
                blank_q <= is_blank;
                if (code_ok) dig_q <= hex;
            end else begin
                if (age_q != AGE_W'(TIMEOUT_CYC)) age_q <= age_q + 1'b1;
                if (age_q == AGE_W'(TIMEOUT_CYC - 1)) vld_q <= 1'b0;
            end
        end

        assign digit_out[4*g +: 4] = dig_q;
        assign digit_vld[g]        = vld_q;
        assign digit_blank[g]      = blank_q;

`ifdef SEG7_CAPTURE_DP_EN
        logic dp_q;
        always_ff @(posedge clk or posedge rst) begin
            if (rst)      dp_q <= 1'b0;
            else if (hit) dp_q <= ~s_dp;
        end
        assign dp_out[g] = dp_q;
`endif
    end

    logic             upd_q, err_code_q, err_multi_q;
    logic [IDX_W-1:0] upd_idx_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upd_q       <= 1'b0;
            upd_idx_q   <= '0;
            err_code_q  <= 1'b0;
            err_multi_q <= 1'b0;
        end else begin
            upd_q       <= cap_ok;
            if (cap_ok) upd_idx_q <= idx;
            err_code_q  <= (stable && one_low && !code_ok && !is_blank) || (err_code_q && !err_clr);
            err_multi_q <= (stable && !one_low && !all_off) || (err_multi_q && !err_clr);
        end
    end

    assign upd       = upd_q;
    assign upd_idx   = upd_idx_q;
    assign err_code  = err_code_q;
    assign err_multi = err_multi_q;
endmodule

// File: tb/tb_seg7_capture.sv
// Bench for seg7_capture: directed scenarios plus random scans, checked every
// cycle against a run-length / timestamp model of the display bus.
module tb_seg7_capture;
    localparam int N = 4;
    localparam int S = 4;
    localparam int T = 128;

    logic           clk = 1'b0, rst = 1'b0;
    logic [6:0]     seg_in = 7'h7F;
    logic [N-1:0]   an_in = '1;
    logic           err_clr = 1'b0;
    logic [4*N-1:0] digit_out;
    logic [N-1:0]   digit_vld, digit_blank;
    logic           upd;
    logic [1:0]     upd_idx;
    logic           err_code, err_multi;

    seg7_capture #(.N_DIGITS(N), .STABLE_CYC(S), .TIMEOUT_CYC(T)) dut (
        .clk(clk), .rst(rst), .seg_in(seg_in), .an_in(an_in), .err_clr(err_clr),
        .digit_out(digit_out), .digit_vld(digit_vld), .digit_blank(digit_blank),
        .upd(upd), .upd_idx(upd_idx), .err_code(err_code), .err_multi(err_multi));

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int cyc = 0, upd_cnt = 0, last_idx = -1, cap_cyc = -1;
    bit chk_en = 0;

    logic [6:0] codes [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Model state: pin history two samples deep, run length of identical samples,
    // and per-digit capture timestamps for staleness.
    logic [6:0] m_seg1, m_seg2, m_pseg;
    logic [N-1:0] m_an1, m_an2, m_pan;
    int run, edge_n, m_idx;
    int cap_edge [N];
    logic [3:0] m_dig [N];
    logic [N-1:0] m_vld, m_blank;
    logic m_upd, m_ec, m_em;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lookup(input logic [6:0] c);
        for (int i = 0; i < 16; i++) if (codes[i] == c) return i;
        return -1;
    endfunction

    function automatic logic [4*N-1:0] m_digits();
        logic [4*N-1:0] v;
        for (int i = 0; i < N; i++) v[4*i +: 4] = m_dig[i];
        return v;
    endfunction

    task automatic m_reset();
        m_seg1 = '1; m_seg2 = '1; m_pseg = '1;
        m_an1 = '1; m_an2 = '1; m_pan = '1;
        run = 0; edge_n = 0; m_idx = 0;
        m_vld = '0; m_blank = '0; m_upd = 0; m_ec = 0; m_em = 0;
        for (int i = 0; i < N; i++) begin m_dig[i] = '0; cap_edge[i] = 0; end
    endtask

    task automatic model_edge();
        logic [6:0] cs;
        logic [N-1:0] ca;
        int nlow, li, h, capd;
        bit ec_s, em_s;
        cs = m_seg2; ca = m_an2; edge_n++;
        if (cs == m_pseg && ca == m_pan) begin
            if (run < 100000) run++;
        end else run = 1;
        m_pseg = cs; m_pan = ca;
        nlow = 0; li = 0;
        for (int i = 0; i < N; i++) if (!ca[i]) begin nlow++; li = i; end
        m_upd = 0; ec_s = 0; em_s = 0; capd = -1; h = lookup(cs);
        if (nlow > 1 && run >= S) em_s = 1;
        if (nlow == 1 && run >= S) begin
            if (h < 0 && cs != 7'h7F) ec_s = 1;
            else if (run == S) begin
                capd = li; m_upd = 1; m_idx = li; cap_edge[li] = edge_n;
                if (h >= 0) begin m_dig[li] = h[3:0]; m_vld[li] = 1; m_blank[li] = 0; end
                else begin m_vld[li] = 0; m_blank[li] = 1; end
            end
        end
        for (int d = 0; d < N; d++)
            if (d != capd && edge_n - cap_edge[d] == T) m_vld[d] = 0;
        m_ec = ec_s || (m_ec && !err_clr);
        m_em = em_s || (m_em && !err_clr);
        m_seg2 = m_seg1; m_seg1 = seg_in;
        m_an2 = m_an1; m_an1 = an_in;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("digit_out", 32'(digit_out), 32'(m_digits()));
            chk("digit_vld", 32'(digit_vld), 32'(m_vld));
            chk("digit_blank", 32'(digit_blank), 32'(m_blank));
            chk("upd", 32'(upd), 32'(m_upd));
            if (m_upd) chk("upd_idx", 32'(upd_idx), 32'(m_idx));
            chk("err_code", 32'(err_code), 32'(m_ec));
            chk("err_multi", 32'(err_multi), 32'(m_em));
            if (upd) begin
                upd_cnt++;
                last_idx = int'(upd_idx);
                if (upd_idx == 2'd2) cap_cyc = cyc;
            end
        end
    end

    task automatic cycle(input logic [N-1:0] an, input logic [6:0] seg, input logic clr);
        an_in = an; seg_in = seg; err_clr = clr;
        @(posedge clk);
        if (!rst) model_edge();
        #1;
    endtask

    task automatic hold(input logic [N-1:0] an, input logic [6:0] seg, input int n);
        repeat (n) cycle(an, seg, 1'b0);
    endtask

    task automatic idle(input int n);
        hold('1, 7'h7F, n);
    endtask

    initial begin
        int base, r, len, a, b;
        logic [N-1:0] an;
        logic [6:0] sg;
        #1 rst = 1'b1; m_reset();
        #2 chk_en = 1;
        idle(3);
        chk("rst_digit_out", 32'(digit_out), 32'h0);
        chk("rst_vld", 32'(digit_vld), 32'h0);
        chk("rst_flags", 32'({upd, err_code, err_multi, digit_blank}), 32'h0);
        rst = 1'b0;
        idle(2);

        // 1: single digit capture
        base = upd_cnt;
        hold(4'b1110, 7'h30, 10); idle(3);
        chk("t1_upd_count", 32'(upd_cnt - base), 32'd1);
        chk("t1_upd_idx", 32'(last_idx), 32'd0);
        chk("t1_digit0", 32'(digit_out[3:0]), 32'h3);
        chk("t1_vld", 32'(digit_vld), 32'b0001);

        // 2: full scan with a blank digit
        base = upd_cnt;
        hold(4'b1110, 7'h02, 20); hold(4'b1101, 7'h08, 20);
        hold(4'b1011, 7'h46, 20); hold(4'b0111, 7'h7F, 20); idle(4);
        chk("t2_digits", 32'(digit_out[11:0]), 32'hCA6);
        chk("t2_vld", 32'(digit_vld), 32'b0111);
        chk("t2_blank", 32'(digit_blank), 32'b1000);
        chk("t2_upd_count", 32'(upd_cnt - base), 32'd4);

        // 3: flicker is rejected, then a steady pattern is taken once
        base = upd_cnt;
        for (int j = 0; j < 10; j++) hold(4'b1101, j[0] ? 7'h24 : 7'h79, 2);
        chk("t3_no_upd", 32'(upd_cnt - base), 32'd0);
        hold(4'b1101, 7'h30, 8); idle(4);
        chk("t3_one_upd", 32'(upd_cnt - base), 32'd1);

        // 4: two anodes together
        hold(4'b1100, 7'h40, 10);
        chk("t4_err_multi", 32'(err_multi), 32'd1);
        chk("t4_digits", 32'(digit_out), 32'h0C36);
        cycle(4'b1100, 7'h40, 1'b1); hold(4'b1100, 7'h40, 2);
        chk("t4_multi_sticky", 32'(err_multi), 32'd1);
        idle(4); cycle('1, 7'h7F, 1'b1);
        chk("t4_multi_clr", 32'(err_multi), 32'd0);

        // 5: undecodable pattern
        hold(4'b1101, 7'h55, 10); idle(4);
        chk("t5_err_code", 32'(err_code), 32'd1);
        chk("t5_vld1", 32'(digit_vld[1]), 32'd1);
        chk("t5_digit1", 32'(digit_out[7:4]), 32'h3);

        // 6: staleness on digit 2, then reset while settling
        cycle('1, 7'h7F, 1'b1);
        cap_cyc = -1;
        hold(4'b1011, 7'h19, 10);
        chk("t6_cap2_seen", 32'(cap_cyc >= 0), 32'd1);
        for (int k = 0; k < T + 20 && cyc < cap_cyc + T - 1; k++) idle(1);
        chk("t6_vld2_before", 32'(digit_vld[2]), 32'd1);
        idle(1);
        chk("t6_vld2_stale", 32'(digit_vld[2]), 32'd0);
        chk("t6_digit2_kept", 32'(digit_out[11:8]), 32'h4);
        hold(4'b1110, 7'h40, 3);
        #2 rst = 1'b1; m_reset();
        #1;
        chk("t6_rst_digits", 32'(digit_out), 32'h0);
        chk("t6_rst_flags", 32'({digit_vld, digit_blank, upd, err_code, err_multi}), 32'h0);
        idle(2);
        rst = 1'b0;
        idle(2);

        // random scanning traffic
        for (int s = 0; s < 200; s++) begin
            r = $urandom_range(0, 9);
            if (r == 0) an = '1;
            else if (r == 1) begin
                a = $urandom_range(0, 3);
                b = (a + 1 + $urandom_range(0, 2)) % 4;
                an = ~((4'b0001 << a) | (4'b0001 << b));
            end else an = ~(4'b0001 << $urandom_range(0, 3));
            r = $urandom_range(0, 9);
            if (r == 0) sg = 7'h7F;
            else if (r == 1) sg = 7'($urandom);
            else sg = codes[$urandom_range(0, 15)];
            len = $urandom_range(1, 12);
            repeat (len) cycle(an, sg, ($urandom_range(0, 7) == 0));
        end
        idle(T + 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
